// File: rtl/clock_divider_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_multi_pkg;

  // Divisor loaded into every channel at reset unless overridden.
  localparam int unsigned DEFAULT_DIV_DEF = 12000000;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: tick every N enabled cycles, square wave of period 2N,
// glitch-free reload at the terminal count, halt on a zero divisor.
module clock_divider_channel
  import clock_divider_multi_pkg::*;
#(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick,
  output logic             clk_out,
  output logic             halted
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] next_div;

  // Next-state logic: halt handling, countdown, terminal reload, pending capture.
  always_comb begin
    count_d      = count_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    clk_out_d    = clk_out_q;
    halted_d     = halted_q;

    // A same-edge load beats the pending value, which beats the current divisor.
    if (load)              next_div = load_value;
    else if (pend_valid_q) next_div = pend_q;
    else                   next_div = active_q;

    if (active_q == ZERO) begin
      // Halted: only a load restarts the channel, regardless of enable.
      if (load) begin
        active_d     = load_value;
        count_d      = (load_value == ZERO) ? ZERO : load_value - ONE;
        halted_d     = (load_value == ZERO);
        pend_valid_d = 1'b0;
      end
    end else if (enable && count_q == ZERO) begin
      tick_d       = 1'b1;
      clk_out_d    = ~clk_out_q;
      active_d     = next_div;
      count_d      = (next_div == ZERO) ? ZERO : next_div - ONE;
      halted_d     = (next_div == ZERO);
      pend_valid_d = 1'b0;
    end else begin
      if (enable) count_d = count_q - ONE;
      // Mid-period loads wait for the terminal count so no runt pulse appears.
      if (load) begin
        pend_d       = load_value;
        pend_valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= DEF_DIV - ONE;
      active_q     <= DEF_DIV;
      pend_q       <= ZERO;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      clk_out_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      clk_out_q    <= clk_out_d;
      halted_q     <= halted_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign halted  = halted_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: decodes divisor loads and
// replicates one independent divider per channel.
module clock_divider_multi
  import clock_divider_multi_pkg::*;
#(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int unsigned CH_W       = ch_w(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                div_load,
  input  logic [CH_W-1:0]     div_ch,
  input  logic [WIDTH-1:0]    div_value,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] halted
);

  logic [CHANNELS-1:0] load_c;

  // Per-channel load strobes; selects beyond the last channel match nothing.
  always_comb begin
    load_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      load_c[i] = div_load && (div_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .enable     (enable),
      .load       (load_c[g]),
      .load_value (div_value),
      .tick       (tick[g]),
      .clk_out    (clk_out[g]),
      .halted     (halted[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi against a period/elapsed-cycle model.
module tb_clock_divider_multi;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned DEF      = 4;
  localparam int unsigned CH_W     = 2;

  logic                clk_in = 1'b0;
  logic                reset_n = 1'b0;
  logic                enable = 1'b0;
  logic                div_load = 1'b0;
  logic [CH_W-1:0]     div_ch = '0;
  logic [WIDTH-1:0]    div_value = '0;
  logic [CHANNELS-1:0] tick, clk_out, halted;

  int checks = 0;
  int passes = 0;

  // Model: period length, enabled edges elapsed in the current period, pending divisor.
  int                  m_n   [CHANNELS];
  int                  m_el  [CHANNELS];
  int                  m_pend[CHANNELS];
  bit                  m_pv  [CHANNELS];
  logic [CHANNELS-1:0] m_tick, m_clk, m_halt;

  clock_divider_multi #(
    .WIDTH       (WIDTH),
    .CHANNELS    (CHANNELS),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .div_load  (div_load),
    .div_ch    (div_ch),
    .div_value (div_value),
    .tick      (tick),
    .clk_out   (clk_out),
    .halted    (halted)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_n[c] = DEF; m_el[c] = 0; m_pend[c] = 0; m_pv[c] = 0;
    end
    m_tick = '0; m_clk = '0; m_halt = '0;
  endtask

  // Apply inputs for one rising edge, advance the model, settle 1 time unit past the edge.
  task automatic step(input bit en, input bit ld, input int ch, input int v);
    int nn;
    bit lc;
    enable = en; div_load = ld; div_ch = CH_W'(ch); div_value = WIDTH'(v);
    @(posedge clk_in);
    for (int c = 0; c < CHANNELS; c++) begin
      lc = ld && (ch == c);
      m_tick[c] = 1'b0;
      if (m_n[c] == 0) begin
        if (lc) begin
          m_n[c] = v; m_el[c] = 0; m_pv[c] = 0; m_halt[c] = (v == 0);
        end
      end else if (en && (m_el[c] + 1 == m_n[c])) begin
        nn = lc ? v : (m_pv[c] ? m_pend[c] : m_n[c]);
        m_tick[c] = 1'b1; m_clk[c] = ~m_clk[c];
        m_n[c] = nn; m_el[c] = 0; m_pv[c] = 0; m_halt[c] = (nn == 0);
      end else begin
        if (en) m_el[c]++;
        if (lc) begin m_pend[c] = v; m_pv[c] = 1; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if ({tick, clk_out, halted} !== '0)
      $display("FAIL reset: got tick=%b clk_out=%b halted=%b, want all zero", tick, clk_out, halted);
    else passes++;
    reset_n = 1'b1;
  endtask

  task automatic test_default_run();
    for (int e = 1; e <= 12; e++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL default_run edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
      if (e == 4 || e == 8) begin
        checks++;
        if (tick[0] !== 1'b1 || clk_out[0] !== (e == 4))
          $display("FAIL default_edge%0d: got tick0=%b clk0=%b want tick0=1 clk0=%b", e, tick[0], clk_out[0], e == 4);
        else passes++;
      end
    end
  endtask

  task automatic test_reload();
    for (int e = 1; e <= 26; e++) begin
      step(1, e == 2, 0, 6);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL reload edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
    end
  endtask

  task automatic test_halt();
    for (int e = 1; e <= 62; e++) begin
      step(1, e == 1 || e == 50, 1, (e == 50) ? 3 : 0);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL halt edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
      if (e == 49) begin
        checks++;
        if (halted[1] !== 1'b1 || tick[1] !== 1'b0)
          $display("FAIL halt_hold: got halted1=%b tick1=%b want 1/0", halted[1], tick[1]);
        else passes++;
      end
    end
  endtask

  task automatic test_enable_gate();
    for (int e = 1; e <= 30; e++) begin
      step(!(e > 5 && e <= 15), e == 10, 2, 5);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL enable_gate edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
    end
  endtask

  task automatic test_n1();
    for (int e = 1; e <= 24; e++) begin
      step(1, e == 1 || e == 14, 0, (e == 14) ? 2 : 1);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL n1 edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
    end
  endtask

  task automatic test_bad_ch();
    for (int e = 1; e <= 12; e++) begin
      step(1, 1, 3, e % 2);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL bad_ch edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
    end
  endtask

  task automatic test_random();
    bit en, ld;
    int ch, v;
    for (int e = 1; e <= 500; e++) begin
      en = ($urandom_range(0, 9) < 8);
      ld = ($urandom_range(0, 9) < 2);
      ch = $urandom_range(0, 3);
      v  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9);
      step(en, ld, ch, v);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL random edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    // Ensure non-zero outputs, then leave a pending load behind before reset.
    for (int e = 1; e <= 6; e++) step(1, e == 6, 0, 9);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({tick, clk_out, halted} !== '0)
      $display("FAIL async_reset: got tick=%b clk_out=%b halted=%b, want all zero", tick, clk_out, halted);
    else passes++;
    @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({tick, clk_out, halted} !== {m_tick, m_clk, m_halt})
        $display("FAIL post_reset edge %0d: got %b/%b/%b want %b/%b/%b", e, tick, clk_out, halted, m_tick, m_clk, m_halt);
      else passes++;
      if (e == 4) begin
        checks++;
        if (tick !== 3'b111)
          $display("FAIL post_reset_default: got tick=%b want 111", tick);
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_reload();
    test_halt();
    test_enable_gate();
    test_n1();
    test_bad_ch();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
